counter_checker: RTL and testbench
==================================

COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the width of the checked count.
REQ-002 The block SHALL have parameter LOSS_THRESHOLD, default 3, which sets how many consecutive bad samples drop lock.
REQ-003 The block SHALL have parameter RESYNC_THRESHOLD, default 2, which sets how many consecutive good samples regain lock.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port Valid, input, 1 bit: Data_In/OV_In carry a sample this cycle.
REQ-007 The block SHALL have port Clear_In, input, 1 bit: the sampled count was cleared, so 0 is expected.
REQ-008 The block SHALL have port Data_In, input, WIDTH bits: the count value under check.
REQ-009 The block SHALL have port OV_In, input, 1 bit: the overflow flag accompanying Data_In.
REQ-010 The block SHALL have port Locked, output, 1 bit: the checker is tracking the sequence.
REQ-011 The block SHALL have port Err, output, 1 bit: a one-cycle pulse for a sequence mismatch.
REQ-012 The block SHALL have port OV_Err, output, 1 bit: a one-cycle pulse when OV_In disagrees with the expected overflow.
REQ-013 The block SHALL have port Err_Count, output, 8 bits: saturating count of Err pulses.
REQ-014 The block SHALL have port Wrap_Count, output, 8 bits: count of correct wrap events (all-ones to 0), modulo 256.
REQ-015 The block SHALL have port Last_Data, output, WIDTH bits: the last accepted sample.

Function
REQ-016 All outputs SHALL be registered and SHALL reflect a Valid sample one cycle after the edge that samples it.
REQ-017 Samples with Valid=0 SHALL be ignored, with no state change and Err and OV_Err low.
REQ-018 The FSM SHALL have three states: IDLE, TRACK and LOST.
REQ-019 In IDLE, the first Valid sample SHALL load the expected value as Data_In+1 (mod 2^WIDTH), go to TRACK, and raise no error.
REQ-020 In TRACK, a sample is good when Data_In equals the expected value, or when Clear_In=1 and Data_In=0; any other sample is bad.
REQ-021 Each bad sample in TRACK SHALL pulse Err.
REQ-022 LOSS_THRESHOLD consecutive bad samples SHALL move the FSM from TRACK to LOST.
REQ-023 In LOST, Err SHALL stay low, and the expected value SHALL reload as Data_In+1 on every sample.
REQ-024 RESYNC_THRESHOLD consecutive good samples SHALL move the FSM from LOST to TRACK.
REQ-025 Locked SHALL be 1 only in TRACK.
REQ-026 On every Valid sample, whether good or bad, the expected value SHALL update to Data_In+1 and Last_Data SHALL update to Data_In.
REQ-027 Expected overflow SHALL be 1 exactly when Last_Data is all-ones, Data_In=0, Clear_In=0, and the state is TRACK.
REQ-028 In TRACK, OV_Err SHALL pulse when OV_In differs from the expected overflow.
REQ-029 A correct wrap (expected overflow=1 and the sample good) SHALL increment Wrap_Count, which rolls from 255 to 0.
REQ-030 Err_Count SHALL saturate at 255.
REQ-031 If Clear_In=1 with Data_In not equal to 0, the sample SHALL be bad.
REQ-032 If Clear_In=1 with Data_In=0 arrives at the point where an all-ones-to-0 wrap would occur, the sample SHALL be good with no Wrap_Count increment and no expected overflow.

Reset
REQ-033 Reset=1 at a rising edge SHALL force state IDLE, Locked=0, Err=0, OV_Err=0, Err_Count=0, Wrap_Count=0, Last_Data=0, and both run counters to 0.
REQ-034 Reset SHALL take priority over Valid in the same cycle.
REQ-035 Reset asserted mid-run SHALL discard any partial run count.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE, TRACK, LOST) and the default threshold constants.
REQ-037 The block SHALL contain one sub-module, sat_counter8, an 8-bit increment-with-saturate counter, instanced for Err_Count.
REQ-038 All other logic SHALL be flat in counter_checker.

Verification
REQ-039 Scenario 1: release Reset, then Valid samples 0x00..0x05 -> Locked=1 from the cycle after the second sample; Err never pulses; Err_Count=0.
REQ-040 Scenario 2: samples 0xFD, 0xFE, 0xFF, 0x00 with OV_In=1 on 0x00 -> Wrap_Count=1 and OV_Err=0; repeating with OV_In=0 on 0x00 -> exactly one OV_Err pulse.
REQ-041 Scenario 3: while locked, the sequence 0x10, 0x11, 0x20 -> one Err pulse; Locked stays 1; Err_Count=1.
REQ-042 Scenario 4: samples 0x10, 0x11, then 0x40, 0x50, 0x60 -> three Err pulses and Locked=0 after the third; then 0x61, 0x62 -> Locked=1 after 0x62.
REQ-043 Scenario 5: at 0x33, Clear_In=1 with Data_In=0x00 -> no Err and Last_Data=0x00; Clear_In=1 with Data_In=0x05 -> one Err pulse.
REQ-044 Scenario 6: Reset asserted for one cycle after two bad samples -> all outputs return to reset values; the next sample gives no Err; Err_Count held at 255 does not wrap when another error occurs.

Source files
------------

// File: rtl/counter_checker_pkg.sv
// counter_checker_pkg: FSM state encoding and default thresholds for counter_checker.
package counter_checker_pkg;
    typedef enum logic [1:0] {IDLE, TRACK, LOST} state_e;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LOSS_THRESHOLD = 3;
    localparam int DEF_RESYNC_THRESHOLD = 2;
endpackage

// File: rtl/counter_checker_sat_counter8.sv
// sat_counter8: 8-bit counter that increments on inc_i and holds at 255.
module sat_counter8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    output logic [7:0] count_o
);
    logic [7:0] count_q;
    always_ff @(posedge clk)
        if (rst) count_q <= '0;
        else if (inc_i && count_q != 8'hFF) count_q <= count_q + 8'd1;
    assign count_o = count_q;
endmodule

// File: rtl/counter_checker.sv
// counter_checker: tracks an incrementing count, flags sequence and overflow mismatches,
// and drops/regains lock after runs of bad/good samples.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOSS_THRESHOLD = DEF_LOSS_THRESHOLD,
    parameter int RESYNC_THRESHOLD = DEF_RESYNC_THRESHOLD
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Valid,
    input  logic             Clear_In,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             OV_In,
    output logic             Locked,
    output logic             Err,
    output logic             OV_Err,
    output logic [7:0]       Err_Count,
    output logic [7:0]       Wrap_Count,
    output logic [WIDTH-1:0] Last_Data
);
    state_e           state_q;
    logic [WIDTH-1:0] last_q;
    logic [7:0]       bad_run_q, good_run_q, wrap_q;
    logic             err_q, ov_err_q;
    logic             good, exp_ov, err_hit;
    // The expected value is always Last_Data+1, so it is derived rather than stored.
    always_comb begin
        good    = (Data_In == last_q + WIDTH'(1)) || (Clear_In && Data_In == '0);
        exp_ov  = (state_q == TRACK) && (&last_q) && (Data_In == '0) && !Clear_In;
        err_hit = Valid && state_q == TRACK && !good;
    end
    sat_counter8 u_err_count (
        .clk     (clk),
        .rst     (Reset),
        .inc_i   (err_hit),
        .count_o (Err_Count)
    );
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_q     <= '0;
            bad_run_q  <= '0;
            good_run_q <= '0;
            wrap_q     <= '0;
            err_q      <= 1'b0;
            ov_err_q   <= 1'b0;
        end else begin
            err_q    <= err_hit;
            ov_err_q <= Valid && state_q == TRACK && (OV_In != exp_ov);
            if (Valid) begin
                last_q <= Data_In;
                if (exp_ov && good) wrap_q <= wrap_q + 8'd1;
                case (state_q)
                    IDLE: begin
                        state_q    <= TRACK;
                        bad_run_q  <= '0;
                        good_run_q <= '0;
                    end
                    TRACK: begin
                        if (good) bad_run_q <= '0;
                        else if (bad_run_q + 8'd1 >= 8'(LOSS_THRESHOLD)) begin
                            state_q    <= LOST;
                            bad_run_q  <= '0;
                            good_run_q <= '0;
                        end else bad_run_q <= bad_run_q + 8'd1;
                    end
                    LOST: begin
                        if (!good) good_run_q <= '0;
                        else if (good_run_q + 8'd1 >= 8'(RESYNC_THRESHOLD)) begin
                            state_q    <= TRACK;
                            good_run_q <= '0;
                            bad_run_q  <= '0;
                        end else good_run_q <= good_run_q + 8'd1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign Locked     = state_q == TRACK;
    assign Err        = err_q;
    assign OV_Err     = ov_err_q;
    assign Wrap_Count = wrap_q;
    assign Last_Data  = last_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed scenarios plus randomized traffic against a behavioural model.
module tb_counter_checker;
    localparam int LOSS = 3;
    localparam int RESYNC = 2;
    logic       clk = 1'b0;
    logic       Reset = 1'b1, Valid = 1'b0, Clear_In = 1'b0, OV_In = 1'b0;
    logic [7:0] Data_In = '0;
    logic       Locked, Err, OV_Err;
    logic [7:0] Err_Count, Wrap_Count, Last_Data;
    int n_tests = 0, n_fail = 0;
    int n_err_pulse = 0, n_ov_pulse = 0;
    // reference model: mode 0 = waiting for first sample, 1 = tracking, 2 = lost
    int       m_mode = 0, m_bad = 0, m_good = 0, m_errc = 0, m_wrap = 0;
    bit [7:0] m_last = 0;
    bit       m_err = 0, m_ov = 0;

    counter_checker dut (
        .clk        (clk),
        .Reset      (Reset),
        .Valid      (Valid),
        .Clear_In   (Clear_In),
        .Data_In    (Data_In),
        .OV_In      (OV_In),
        .Locked     (Locked),
        .Err        (Err),
        .OV_Err     (OV_Err),
        .Err_Count  (Err_Count),
        .Wrap_Count (Wrap_Count),
        .Last_Data  (Last_Data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic model(input bit rst, input bit v, input bit c, input bit [7:0] d, input bit o);
        bit [7:0] want;
        bit good, xov;
        if (rst) begin
            m_mode = 0; m_bad = 0; m_good = 0; m_errc = 0; m_wrap = 0;
            m_last = 0; m_err = 0; m_ov = 0;
            return;
        end
        m_err = 0;
        m_ov = 0;
        if (!v) return;
        want = m_last + 8'd1;
        good = (d == want) || (c && d == 0);
        xov = (m_mode == 1) && m_last == 8'hFF && d == 0 && !c;
        m_err = (m_mode == 1) && !good;
        m_ov = (m_mode == 1) && (o != xov);
        if (m_err && m_errc < 255) m_errc++;
        if (xov && good) m_wrap = (m_wrap + 1) % 256;
        if (m_mode == 0) begin
            m_mode = 1; m_bad = 0; m_good = 0;
        end else if (m_mode == 1) begin
            if (good) m_bad = 0;
            else if (++m_bad >= LOSS) begin m_mode = 2; m_bad = 0; m_good = 0; end
        end else begin
            if (!good) m_good = 0;
            else if (++m_good >= RESYNC) begin m_mode = 1; m_good = 0; end
        end
        m_last = d;
    endtask

    task automatic step(input bit rst, input bit v, input bit c, input bit [7:0] d, input bit o);
        Reset = rst; Valid = v; Clear_In = c; Data_In = d; OV_In = o;
        model(rst, v, c, d, o);
        @(posedge clk);
        #1;
        n_err_pulse += int'(Err);
        n_ov_pulse += int'(OV_Err);
        check("Locked", 32'(Locked), 32'(m_mode == 1));
        check("Err", 32'(Err), 32'(m_err));
        check("OV_Err", 32'(OV_Err), 32'(m_ov));
        check("Err_Count", 32'(Err_Count), 32'(m_errc));
        check("Wrap_Count", 32'(Wrap_Count), 32'(m_wrap));
        check("Last_Data", 32'(Last_Data), 32'(m_last));
    endtask

    task automatic sample(input bit [7:0] d, input bit o = 1'b0, input bit c = 1'b0);
        step(1'b0, 1'b1, c, d, o);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        n_err_pulse = 0;
        n_ov_pulse = 0;
    endtask

    initial begin
        bit [7:0] d;
        bit c, o;
        int r;
        // reset dominates a simultaneous valid sample
        step(1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
        check("reset_locked", 32'(Locked), 32'd0);
        check("reset_last", 32'(Last_Data), 32'd0);
        // scenario 1: clean count from zero
        do_reset();
        sample(8'h00);
        sample(8'h01);
        check("s1_locked_after_2nd", 32'(Locked), 32'd1);
        for (int i = 2; i <= 5; i++) sample(8'(i));
        check("s1_err_pulses", 32'(n_err_pulse), 32'd0);
        check("s1_err_count", 32'(Err_Count), 32'd0);
        // scenario 2: wrap with and without the overflow flag
        do_reset();
        sample(8'hFD); sample(8'hFE); sample(8'hFF); sample(8'h00, 1'b1);
        check("s2_wrap", 32'(Wrap_Count), 32'd1);
        check("s2_ov_pulses", 32'(n_ov_pulse), 32'd0);
        sample(8'hFD); sample(8'hFE); sample(8'hFF); sample(8'h00, 1'b0);
        check("s2_ov_pulses_bad", 32'(n_ov_pulse), 32'd1);
        // scenario 3: single jump while locked
        do_reset();
        sample(8'h10); sample(8'h11); sample(8'h20);
        check("s3_err_pulses", 32'(n_err_pulse), 32'd1);
        check("s3_locked", 32'(Locked), 32'd1);
        check("s3_err_count", 32'(Err_Count), 32'd1);
        // scenario 4: lose lock, then regain it
        do_reset();
        sample(8'h10); sample(8'h11); sample(8'h40); sample(8'h50); sample(8'h60);
        check("s4_err_pulses", 32'(n_err_pulse), 32'd3);
        check("s4_unlocked", 32'(Locked), 32'd0);
        sample(8'h61);
        check("s4_still_lost", 32'(Locked), 32'd0);
        sample(8'h62);
        check("s4_relocked", 32'(Locked), 32'd1);
        // scenario 5: clear handling
        do_reset();
        sample(8'h32); sample(8'h33);
        sample(8'h00, 1'b0, 1'b1);
        check("s5_clear_ok_err", 32'(Err), 32'd0);
        check("s5_clear_last", 32'(Last_Data), 32'd0);
        sample(8'h05, 1'b0, 1'b1);
        check("s5_clear_bad_err", 32'(Err), 32'd1);
        // clear at the wrap point: good, no wrap, no expected overflow
        sample(8'hFF); sample(8'h00, 1'b0, 1'b1);
        check("s5_clear_wrap_err", 32'(Err), 32'd0);
        check("s5_clear_wrap_cnt", 32'(Wrap_Count), 32'd0);
        check("s5_clear_wrap_ov", 32'(OV_Err), 32'd0);
        // scenario 6: mid-run reset, then error counter saturation
        do_reset();
        sample(8'h10); sample(8'h40); sample(8'h50);
        do_reset();
        check("s6_reset_errc", 32'(Err_Count), 32'd0);
        check("s6_reset_locked", 32'(Locked), 32'd0);
        sample(8'h77);
        check("s6_first_no_err", 32'(Err), 32'd0);
        for (int i = 0; i < 260; i++) begin
            sample(m_last + 8'd2);
            sample(m_last + 8'd1);
        end
        check("s6_saturated", 32'(Err_Count), 32'd255);
        // idle cycles change nothing
        step(1'b0, 1'b0, 1'b0, 8'h12, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            c = 1'b0;
            if (r < 65) d = m_last + 8'd1;
            else if (r < 72) begin d = 8'h00; c = 1'b1; end
            else if (r < 76) begin d = 8'($urandom); c = 1'b1; end
            else if (r < 82) d = 8'hFE;
            else d = 8'($urandom);
            o = (m_last == 8'hFF && d == 0 && !c) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            step(r < 1, r >= 8, c, d, o);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
